ser_fifo_tx: RTL

Buffered LSB-first serializer: up to 16 parallel words are queued in a distributed-RAM FIFO, then each word is parallel-loaded into a shift register and shifted out one bit per `bit_en` strobe. It sits upstream of the serial line driver, pairing the 16-deep dual-port RAM with a parallel-load shift register under one control FSM. Words are sent back-to-back with no idle bit between them while the FIFO has data.

---
 rtl/ser_fifo_tx.sv | 100 ++++++++++
 1 files changed

// File: rtl/ser_fifo_tx.sv
// Buffered LSB-first serializer: a small distributed-RAM FIFO feeding a
// parallel-load shift register, one bit shifted out per bit_en strobe.
module ser_fifo_tx #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  we,
    input  logic                  bit_en,
    input  logic                  clr_ovf,
    output logic                  sdo,
    output logic                  frame,
    output logic                  word_done,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(WIDTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]            state;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp, rp;
    logic [WIDTH-1:0]      sr;
    logic [CW-1:0]         bcnt;
    logic [DEPTH_LOG2:0]   cnt_nxt;
    logic                  push, pop, last_bit;

    assign push     = we & ~full;
    assign last_bit = (state == S_SHIFT) && bit_en && (bcnt == CW'(WIDTH - 1));
    // Pop either to start from idle or to chain the next word with no gap.
    assign pop      = ~empty & ((state == S_IDLE) | last_bit);

    always_comb begin
        cnt_nxt = count;
        if (push && !pop)
            cnt_nxt = count + (DEPTH_LOG2 + 1)'(1);
        else if (pop && !push)
            cnt_nxt = count - (DEPTH_LOG2 + 1)'(1);
    end

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            ovf       <= 1'b0;
            sr        <= '0;
            bcnt      <= '0;
            word_done <= 1'b0;
        end else begin
            if (push)
                wp <= wp + DEPTH_LOG2'(1);
            count <= cnt_nxt;
            full  <= (cnt_nxt == (DEPTH_LOG2 + 1)'(DEPTH));
            empty <= (cnt_nxt == '0);

            if (we && full)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;

            word_done <= last_bit;

            if (pop) begin
                sr    <= mem[rp];
                rp    <= rp + DEPTH_LOG2'(1);
                bcnt  <= '0;
                state <= S_SHIFT;
            end else if (last_bit) begin
                sr    <= '0;
                bcnt  <= '0;
                state <= S_IDLE;
            end else if (state == S_SHIFT && bit_en) begin
                sr   <= {1'b0, sr[WIDTH-1:1]};
                bcnt <= bcnt + CW'(1);
            end
        end
    end

    assign frame = (state == S_SHIFT);
    assign sdo   = (state == S_SHIFT) & sr[0];

endmodule
